// File: rtl/unidad_carga_alm.sv
// Load/store unit: byte/half/word accesses to a 256-byte big-endian memory,
// with read-modify-write for sub-word stores. Define CHEQUEO_ALINEACION_EN to also reject unaligned half/word accesses.
module unidad_carga_alm (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Inicio,
    input  logic        EsEsc,
    input  logic [1:0]  Tam,
    input  logic        ConSigno,
    input  logic [31:0] DirCPU,
    input  logic [31:0] DatoCPU,
    output logic        Ocupado,
    output logic        Listo,
    output logic [31:0] DatoCarga,
    output logic        Error,
    output logic [31:0] Dir,
    output logic [31:0] DatoE,
    output logic        ESC,
    output logic        Leer,
    input  logic [31:0] DatoS
);

    typedef enum logic [1:0] {REPOSO, LEER, ESCRIBIR, FIN} estado_t;

    estado_t     estado;
    logic        es_esc;
    logic [1:0]  tam_q;
    logic        con_signo_q;
    logic [15:0] dato_cpu_q;

    logic [8:0]  ultimo_c;
    logic [8:0]  fin_acceso_c;
    logic        desalineado_c;
    logic        rechazo_c;
    logic [31:0] carga_c;
    logic [31:0] mezcla_c;

    // Access validation on the raw CPU request, evaluated in REPOSO
    always_comb begin
        ultimo_c = 9'd3;
        case (Tam)
            2'b00:   ultimo_c = 9'd0;
            2'b01:   ultimo_c = 9'd1;
            default: ultimo_c = 9'd3;
        endcase
        fin_acceso_c = {1'b0, DirCPU[7:0]} + ultimo_c;
`ifdef CHEQUEO_ALINEACION_EN
        desalineado_c = ((Tam == 2'b01) && DirCPU[0]) ||
                        ((Tam == 2'b10) && (DirCPU[1:0] != 2'b00));
`else
        desalineado_c = 1'b0;
`endif
        rechazo_c = (Tam == 2'b11) || (DirCPU[31:8] != 24'd0) ||
                    fin_acceso_c[8] || desalineado_c;
    end

    // Load extraction and sub-word store merge from the memory word
    always_comb begin
        carga_c  = DatoS;
        mezcla_c = {dato_cpu_q[15:0], DatoS[15:0]};
        case (tam_q)
            2'b00: begin
                carga_c  = {{24{con_signo_q & DatoS[31]}}, DatoS[31:24]};
                mezcla_c = {dato_cpu_q[7:0], DatoS[23:0]};
            end
            2'b01:   carga_c = {{16{con_signo_q & DatoS[31]}}, DatoS[31:16]};
            default: carga_c = DatoS;
        endcase
    end

    // Control FSM with all outputs registered
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            estado      <= REPOSO;
            es_esc      <= 1'b0;
            tam_q       <= 2'b00;
            con_signo_q <= 1'b0;
            dato_cpu_q  <= 16'd0;
            Ocupado     <= 1'b0;
            Listo       <= 1'b0;
            Error       <= 1'b0;
            ESC         <= 1'b0;
            Leer        <= 1'b0;
            Dir         <= 32'd0;
            DatoE       <= 32'd0;
            DatoCarga   <= 32'd0;
        end else begin
            Listo <= 1'b0;
            Error <= 1'b0;
            ESC   <= 1'b0;
            Leer  <= 1'b0;
            case (estado)
                REPOSO: begin
                    if (Inicio) begin
                        Ocupado <= 1'b1;
                        if (rechazo_c) begin
                            estado <= FIN;
                            Listo  <= 1'b1;
                            Error  <= 1'b1;
                        end else begin
                            es_esc      <= EsEsc;
                            tam_q       <= Tam;
                            con_signo_q <= ConSigno;
                            dato_cpu_q  <= DatoCPU[15:0];
                            Dir         <= DirCPU;
                            if (EsEsc && (Tam == 2'b10)) begin
                                estado <= ESCRIBIR;
                                ESC    <= 1'b1;
                                DatoE  <= DatoCPU;
                            end else begin
                                estado <= LEER;
                                Leer   <= 1'b1;
                            end
                        end
                    end
                end
                LEER: begin
                    if (es_esc) begin
                        estado <= ESCRIBIR;
                        ESC    <= 1'b1;
                        DatoE  <= mezcla_c;
                    end else begin
                        estado    <= FIN;
                        Listo     <= 1'b1;
                        DatoCarga <= carga_c;
                    end
                end
                ESCRIBIR: begin
                    estado <= FIN;
                    Listo  <= 1'b1;
                end
                FIN: begin
                    estado  <= REPOSO;
                    Ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unidad_carga_alm.sv
// Directed bench for unidad_carga_alm with a byte-memory model and result scoreboard.
// Honours CHEQUEO_ALINEACION_EN the same way as the design build.
module tb_unidad_carga_alm;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Inicio;
    logic        EsEsc;
    logic [1:0]  Tam;
    logic        ConSigno;
    logic [31:0] DirCPU;
    logic [31:0] DatoCPU;
    logic        Ocupado;
    logic        Listo;
    logic [31:0] DatoCarga;
    logic        Error;
    logic [31:0] Dir;
    logic [31:0] DatoE;
    logic        ESC;
    logic        Leer;
    logic [31:0] DatoS;

    logic [7:0]  mem    [256];
    logic [7:0]  modelo [256];
    logic [31:0] carga_modelo;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        err;
        logic [31:0] carga;
        int          lat;
        int          leer;
        int          esc;
        logic [31:0] dato_e;
    } esperado_t;

    esperado_t sb[$];

    always #5 CLK = ~CLK;

    assign DatoS = {mem[Dir[7:0]], mem[8'(Dir[7:0] + 8'd1)],
                    mem[8'(Dir[7:0] + 8'd2)], mem[8'(Dir[7:0] + 8'd3)]};

    unidad_carga_alm dut (
        .CLK(CLK), .RST(RST), .Inicio(Inicio), .EsEsc(EsEsc), .Tam(Tam),
        .ConSigno(ConSigno), .DirCPU(DirCPU), .DatoCPU(DatoCPU),
        .Ocupado(Ocupado), .Listo(Listo), .DatoCarga(DatoCarga), .Error(Error),
        .Dir(Dir), .DatoE(DatoE), .ESC(ESC), .Leer(Leer), .DatoS(DatoS)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] palabra_modelo(input logic [7:0] a);
        return {modelo[a], modelo[8'(a + 8'd1)], modelo[8'(a + 8'd2)], modelo[8'(a + 8'd3)]};
    endfunction

    // Drives one access, predicts its outcome, then checks the DUT response
    task automatic acceso(input string tag, input logic es, input logic [1:0] tam,
                          input logic signo, input logic [31:0] dir, input logic [31:0] dato);
        esperado_t   e;
        esperado_t   r;
        int          nbytes;
        logic        rech;
        logic [7:0]  a;
        logic [31:0] w;
        int          leer_n = 0;
        int          esc_n = 0;
        int          lat = 0;
        logic        got = 1'b0;
        logic        err_obs = 1'b0;
        logic        dir_ok = 1'b1;
        logic [31:0] dato_e_obs = 32'd0;

        nbytes = (tam == 2'b00) ? 1 : (tam == 2'b01) ? 2 : 4;
        rech = (tam == 2'b11) || (dir[31:8] != 24'd0) || (int'(dir[7:0]) + nbytes - 1 > 255);
`ifdef CHEQUEO_ALINEACION_EN
        if ((tam == 2'b01) && dir[0]) rech = 1'b1;
        if ((tam == 2'b10) && (dir[1:0] != 2'b00)) rech = 1'b1;
`endif
        a = dir[7:0];
        w = palabra_modelo(a);
        e.err = rech; e.lat = 1; e.leer = 0; e.esc = 0; e.dato_e = 32'd0;
        if (rech) begin
            e.lat = 1;
        end else if (!es) begin
            e.lat = 2; e.leer = 1;
            if (tam == 2'b00)      carga_modelo = {{24{signo & w[31]}}, w[31:24]};
            else if (tam == 2'b01) carga_modelo = {{16{signo & w[31]}}, w[31:16]};
            else                   carga_modelo = w;
        end else begin
            e.esc = 1;
            if (tam == 2'b10) begin
                e.lat = 2; e.dato_e = dato;
            end else begin
                e.lat = 3; e.leer = 1;
                e.dato_e = (tam == 2'b00) ? {dato[7:0], w[23:0]} : {dato[15:0], w[15:0]};
            end
            for (int i = 0; i < nbytes; i++)
                modelo[8'(a + 8'(i))] = dato[8*(nbytes-1-i) +: 8];
        end
        e.carga = carga_modelo;
        sb.push_back(e);

        @(negedge CLK);
        EsEsc = es; Tam = tam; ConSigno = signo; DirCPU = dir; DatoCPU = dato; Inicio = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge CLK);
            if (n == 1) Inicio = 1'b0;
            if (Leer) begin
                leer_n++;
                if (Dir !== dir) dir_ok = 1'b0;
            end
            if (ESC) begin
                esc_n++;
                dato_e_obs = DatoE;
                if (Dir !== dir) dir_ok = 1'b0;
                for (int i = 0; i < 4; i++)
                    mem[8'(Dir[7:0] + 8'(i))] = DatoE[8*(3-i) +: 8];
            end
            if (Listo) begin
                got = 1'b1; lat = n; err_obs = Error;
                break;
            end
        end
        r = sb.pop_front();
        chk({tag, " listo"}, 32'(got), 32'd1);
        chk({tag, " latencia"}, 32'(lat), 32'(r.lat));
        chk({tag, " error"}, 32'(err_obs), 32'(r.err));
        chk({tag, " carga"}, DatoCarga, r.carga);
        chk({tag, " leer"}, 32'(leer_n), 32'(r.leer));
        chk({tag, " esc"}, 32'(esc_n), 32'(r.esc));
        chk({tag, " dir"}, 32'(dir_ok), 32'd1);
        if (r.esc != 0) chk({tag, " dato_e"}, dato_e_obs, r.dato_e);
        @(negedge CLK);
        chk({tag, " pulso"}, 32'({Listo, Ocupado}), 32'd0);
    endtask

    task automatic chk_mem(input string tag, input logic [7:0] a, input int n);
        for (int i = 0; i < n; i++)
            chk(tag, 32'(mem[8'(a + 8'(i))]), 32'(modelo[8'(a + 8'(i))]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int esc_n;
        int listo_n;
        int t1;
        int t2;
        logic [31:0] w;

        RST = 1'b1; Inicio = 1'b0; EsEsc = 1'b0; Tam = 2'b00; ConSigno = 1'b0;
        DirCPU = 32'd0; DatoCPU = 32'd0; carga_modelo = 32'd0;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'(i) ^ 8'h5A;
            modelo[i] = 8'(i) ^ 8'h5A;
        end
        mem[8'h10] = 8'h80; mem[8'h11] = 8'h12; mem[8'h12] = 8'h34; mem[8'h13] = 8'h56;
        modelo[8'h10] = 8'h80; modelo[8'h11] = 8'h12; modelo[8'h12] = 8'h34; modelo[8'h13] = 8'h56;

        repeat (2) @(negedge CLK);
        chk("reset salidas", 32'({Ocupado, Listo, Error, ESC, Leer}), 32'd0);
        chk("reset dir", Dir, 32'd0);
        chk("reset dato_e", DatoE, 32'd0);
        chk("reset carga", DatoCarga, 32'd0);
        RST = 1'b0;

        acceso("lb con signo", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
        acceso("lb sin signo", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        acceso("lh con signo", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
        acceso("lh sin signo", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        acceso("lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        acceso("sh beef", 1'b1, 2'b01, 1'b0, 32'h10, 32'h0000BEEF);
        chk_mem("mem sh beef", 8'h10, 4);
        acceso("lw tras sh", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        acceso("lw fuera rango", 1'b0, 2'b10, 1'b0, 32'hFD, 32'h0);
        acceso("tam reservado", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        acceso("dir alta", 1'b0, 2'b00, 1'b0, 32'h100, 32'h0);
        acceso("lw limite", 1'b0, 2'b10, 1'b0, 32'hFC, 32'h0);
        acceso("sb limite", 1'b1, 2'b00, 1'b0, 32'hFF, 32'h000000AB);
        chk_mem("mem sb limite", 8'hFF, 1);
        acceso("lb limite", 1'b0, 2'b00, 1'b1, 32'hFF, 32'h0);
        acceso("sw desalineado", 1'b1, 2'b10, 1'b0, 32'h21, 32'hCAFEF00D);
        chk_mem("mem sw 21", 8'h21, 4);
        acceso("lh impar", 1'b0, 2'b01, 1'b1, 32'h13, 32'h0);
        acceso("sw alineado", 1'b1, 2'b10, 1'b0, 32'h40, 32'h89ABCDEF);
        chk_mem("mem sw 40", 8'h40, 4);

        // Reset in the middle of a byte store read phase
        @(negedge CLK);
        EsEsc = 1'b1; Tam = 2'b00; ConSigno = 1'b0; DirCPU = 32'h30; DatoCPU = 32'h77; Inicio = 1'b1;
        @(negedge CLK);
        Inicio = 1'b0;
        chk("rst leer activo", 32'(Leer), 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("rst inmediato", 32'({Ocupado, Leer, ESC, Listo, Error}), 32'd0);
        chk("rst carga", DatoCarga, 32'd0);
        carga_modelo = 32'd0;
        esc_n = 0; listo_n = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge CLK);
            if (n == 1) RST = 1'b0;
            if (ESC) esc_n++;
            if (Listo) listo_n++;
        end
        chk("rst sin esc", 32'(esc_n), 32'd0);
        chk("rst sin listo", 32'(listo_n), 32'd0);
        chk_mem("rst mem", 8'h30, 1);

        // Back-to-back loads with Inicio held high
        w = palabra_modelo(8'h40);
        @(negedge CLK);
        EsEsc = 1'b0; Tam = 2'b01; ConSigno = 1'b0; DirCPU = 32'h40; Inicio = 1'b1;
        listo_n = 0; t1 = 0; t2 = 0;
        for (int n = 1; n <= 9; n++) begin
            @(negedge CLK);
            if (n == 4) Inicio = 1'b0;
            if (Listo) begin
                listo_n++;
                if (listo_n == 1) t1 = n; else t2 = n;
                chk("b2b carga", DatoCarga, {16'd0, w[31:16]});
            end
        end
        carga_modelo = {16'd0, w[31:16]};
        chk("b2b pulsos", 32'(listo_n), 32'd2);
        chk("b2b primero", 32'(t1), 32'd2);
        chk("b2b separacion", 32'(t2 - t1), 32'd3);
        chk("b2b reposo", 32'(Ocupado), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
